// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extend pipeline: format encodings,
// instruction field positions and the output-buffer state encoding.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    FMT_D  = 3'b000,
    FMT_CB = 3'b001,
    FMT_B  = 3'b010,
    FMT_I  = 3'b011,
    FMT_IW = 3'b100
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Field positions inside the 32-bit instruction word
  localparam int D_HI  = 20;
  localparam int D_LO  = 12;
  localparam int CB_HI = 23;
  localparam int CB_LO = 5;
  localparam int B_HI  = 25;
  localparam int B_LO  = 0;
  localparam int I_HI  = 21;
  localparam int I_LO  = 10;
  localparam int IW_HI = 20;
  localparam int IW_LO = 5;
  localparam int HW_HI = 22;
  localparam int HW_LO = 21;

  localparam int D_W  = D_HI - D_LO + 1;
  localparam int CB_W = CB_HI - CB_LO + 1;
  localparam int B_W  = B_HI - B_LO + 1;
  localparam int I_W  = I_HI - I_LO + 1;
  localparam int IW_W = IW_HI - IW_LO + 1;

  // Branch offsets are word offsets; optional scaling to byte offsets
  localparam int BR_SHAMT = 2;

endpackage

// File: rtl/imm_field_decode.sv
// Combinational field extract / extend for every immediate format.
// Illegal formats and IW shifts that do not fit DATA_W yield zero with err_o.
module imm_field_decode
  import imm_ext_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 0
) (
  input  logic [31:0]       imm_i,
  input  logic [2:0]        fmt_i,
  output logic [DATA_W-1:0] imm_o,
  output logic              err_o
);

  logic [1:0]        hw;
  logic [5:0]        iw_shamt;
  logic [6:0]        iw_top;
  logic [DATA_W-1:0] cb_ext;
  logic [DATA_W-1:0] b_ext;
  logic [DATA_W-1:0] iw_base;
  logic              unused_hi;

  assign hw        = imm_i[HW_HI:HW_LO];
  assign iw_shamt  = {hw, 4'b0000};
  assign iw_top    = {1'b0, hw, 4'b0000} + 7'd16;
  assign cb_ext    = {{(DATA_W-CB_W){imm_i[CB_HI]}}, imm_i[CB_HI:CB_LO]};
  assign b_ext     = {{(DATA_W-B_W){imm_i[B_HI]}}, imm_i[B_HI:B_LO]};
  assign iw_base   = {{(DATA_W-IW_W){1'b0}}, imm_i[IW_HI:IW_LO]};
  assign unused_hi = ^imm_i[31:26];

  // Select and extend the field named by the format code
  always_comb begin
    imm_o = '0;
    err_o = 1'b0;
    case (fmt_i)
      FMT_D:  imm_o = {{(DATA_W-D_W){imm_i[D_HI]}}, imm_i[D_HI:D_LO]};
      FMT_CB: imm_o = (BR_SHIFT != 0) ? (cb_ext << BR_SHAMT) : cb_ext;
      FMT_B:  imm_o = (BR_SHIFT != 0) ? (b_ext << BR_SHAMT) : b_ext;
      FMT_I:  imm_o = {{(DATA_W-I_W){1'b0}}, imm_i[I_HI:I_LO]};
      FMT_IW: begin
        // A halfword slot beyond the result width cannot be represented
        if (iw_top > 7'(DATA_W)) begin
          err_o = 1'b1;
        end else begin
          imm_o = iw_base << iw_shamt;
        end
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate-extend stage with a ready/valid handshake on both sides.
// Results sit in a main register with one skid entry behind it, so in_ready
// is a pure register and never depends on out_ready combinationally.
// DATA_W must be 32 or 64.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 0
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Imm32,
  input  logic [2:0]        Ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] BusImm,
  output logic [2:0]        out_fmt,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [DATA_W-1:0] main_imm_q, skid_imm_q;
  logic [2:0]        main_fmt_q, skid_fmt_q;
  logic              main_err_q, skid_err_q;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0] dec_imm;
  logic              dec_err;
  logic              push, pop;
  logic              ld_main_in, ld_main_skid, ld_skid;

  imm_field_decode #(
    .DATA_W   (DATA_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_decode (
    .imm_i (Imm32),
    .fmt_i (Ctrl),
    .imm_o (dec_imm),
    .err_o (dec_err)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = rdy_q;
  assign push      = in_valid && rdy_q;
  assign pop       = out_valid && out_ready;
  assign BusImm    = main_imm_q;
  assign out_fmt   = main_fmt_q;
  assign out_err   = main_err_q;
  assign err_cnt   = err_cnt_q;

  // Buffer occupancy transitions and which register loads from where
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          ld_main_in = 1'b1;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({push, pop})
          2'b10: begin
            ld_skid = 1'b1;
            state_d = ST_FULL;
          end
          2'b11: ld_main_in = 1'b1;
          2'b01: state_d = ST_EMPTY;
          default: ;
        endcase
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can happen
        if (pop) begin
          ld_main_skid = 1'b1;
          state_d      = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Saturating count of accepted illegal transactions
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && dec_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Control state; in_ready is registered from the next state and held low in reset
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q   <= ST_EMPTY;
      rdy_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= (state_d != ST_FULL);
      err_cnt_q <= err_cnt_d;
    end
  end

  // Main output register: fresh decode or the older skid entry
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      main_imm_q <= '0;
      main_fmt_q <= 3'd0;
      main_err_q <= 1'b0;
    end else if (ld_main_skid) begin
      main_imm_q <= skid_imm_q;
      main_fmt_q <= skid_fmt_q;
      main_err_q <= skid_err_q;
    end else if (ld_main_in) begin
      main_imm_q <= dec_imm;
      main_fmt_q <= Ctrl;
      main_err_q <= dec_err;
    end
  end

  // Skid register catches an accept while the main result is stalled
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      skid_imm_q <= '0;
      skid_fmt_q <= 3'd0;
      skid_err_q <= 1'b0;
    end else if (ld_skid) begin
      skid_imm_q <= dec_imm;
      skid_fmt_q <= Ctrl;
      skid_err_q <= dec_err;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 64-bit/no-shift instance and a 32-bit/shift
// instance share one stimulus stream and are checked against a queue model.
module tb_imm_extend_pipe;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] Imm32;
  logic [2:0]  Ctrl;

  logic        ir64, ov64, err64;
  logic [63:0] bus64;
  logic [2:0]  fmt64;
  logic [7:0]  cnt64;
  logic        ir32, ov32, err32;
  logic [31:0] bus32;
  logic [2:0]  fmt32;
  logic [7:0]  cnt32;

  always #5 CLK = ~CLK;

  imm_extend_pipe #(.DATA_W(64), .BR_SHIFT(0)) u_dut64 (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(ir64),
    .Imm32(Imm32), .Ctrl(Ctrl), .out_valid(ov64), .out_ready(out_ready),
    .BusImm(bus64), .out_fmt(fmt64), .out_err(err64), .err_cnt(cnt64)
  );

  imm_extend_pipe #(.DATA_W(32), .BR_SHIFT(1)) u_dut32 (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(ir32),
    .Imm32(Imm32), .Ctrl(Ctrl), .out_valid(ov32), .out_ready(out_ready),
    .BusImm(bus32), .out_fmt(fmt32), .out_err(err32), .err_cnt(cnt32)
  );

  typedef struct {
    logic [63:0] v64;
    logic        e64;
    logic [31:0] v32;
    logic        e32;
    logic [2:0]  fmt;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   exp_rdy = 1'b0;
  int   cnt64_m = 0;
  int   cnt32_m = 0;
  bit   use_fix = 1'b0;
  exp_t fix;

  function automatic logic [64:0] model(input logic [31:0] imm, input logic [2:0] c,
                                        input int dw, input int brs);
    logic [63:0] v;
    logic        e;
    int          hw;
    v  = '0;
    e  = 1'b0;
    hw = int'(imm[22:21]);
    case (c)
      3'd0: v = {{55{imm[20]}}, imm[20:12]};
      3'd1: begin
        v = {{45{imm[23]}}, imm[23:5]};
        if (brs != 0) v = v << 2;
      end
      3'd2: begin
        v = {{38{imm[25]}}, imm[25:0]};
        if (brs != 0) v = v << 2;
      end
      3'd3: v = {52'd0, imm[21:10]};
      3'd4: begin
        if (16 * hw + 16 > dw) e = 1'b1;
        else v = {48'd0, imm[20:5]} << (16 * hw);
      end
      default: e = 1'b1;
    endcase
    if (dw == 32) v[63:32] = '0;
    return {e, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_out_valid64", {63'd0, ov64}, 64'd0);
    chk("rst_in_ready64", {63'd0, ir64}, 64'd0);
    chk("rst_busimm64", bus64, 64'd0);
    chk("rst_fmt64", {61'd0, fmt64}, 64'd0);
    chk("rst_err64", {63'd0, err64}, 64'd0);
    chk("rst_errcnt64", {56'd0, cnt64}, 64'd0);
    chk("rst_out_valid32", {63'd0, ov32}, 64'd0);
    chk("rst_in_ready32", {63'd0, ir32}, 64'd0);
    chk("rst_busimm32", {32'd0, bus32}, 64'd0);
    chk("rst_errcnt32", {56'd0, cnt32}, 64'd0);
  endtask

  task automatic drive(input logic [31:0] imm, input logic [2:0] c);
    in_valid = 1'b1;
    Imm32    = imm;
    Ctrl     = c;
  endtask

  // Called #1 after a rising edge with inputs set; checks, updates the model, advances one cycle
  task automatic cycle();
    exp_t        e, h;
    logic [64:0] r;
    bit          acc, pop;
    chk("in_ready64", {63'd0, ir64}, {63'd0, exp_rdy});
    chk("in_ready32", {63'd0, ir32}, {63'd0, exp_rdy});
    chk("out_valid64", {63'd0, ov64}, {63'd0, sbq.size() != 0});
    chk("out_valid32", {63'd0, ov32}, {63'd0, sbq.size() != 0});
    chk("err_cnt64", {56'd0, cnt64}, 64'(cnt64_m));
    chk("err_cnt32", {56'd0, cnt32}, 64'(cnt32_m));
    if (sbq.size() != 0) begin
      h = sbq[0];
      chk("busimm64", bus64, h.v64);
      chk("out_err64", {63'd0, err64}, {63'd0, h.e64});
      chk("out_fmt64", {61'd0, fmt64}, {61'd0, h.fmt});
      chk("busimm32", {32'd0, bus32}, {32'd0, h.v32});
      chk("out_err32", {63'd0, err32}, {63'd0, h.e32});
      chk("out_fmt32", {61'd0, fmt32}, {61'd0, h.fmt});
    end
    pop = (sbq.size() != 0) && out_ready;
    acc = in_valid && exp_rdy;
    if (pop) void'(sbq.pop_front());
    if (acc) begin
      if (use_fix) begin
        e       = fix;
        use_fix = 1'b0;
      end else begin
        r     = model(Imm32, Ctrl, 64, 0);
        e.v64 = r[63:0];
        e.e64 = r[64];
        r     = model(Imm32, Ctrl, 32, 1);
        e.v32 = r[31:0];
        e.e32 = r[64];
      end
      e.fmt = Ctrl;
      sbq.push_back(e);
      if (e.e64 && cnt64_m < 255) cnt64_m++;
      if (e.e32 && cnt32_m < 255) cnt32_m++;
    end
    exp_rdy = (sbq.size() != 2);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6 && sbq.size() != 0; i++) cycle();
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  logic [31:0] base;

  initial begin
    resetl    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Imm32     = 32'd0;
    Ctrl      = 3'd0;
    #2;
    chk_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    resetl = 1'b1;
    @(posedge CLK);
    #1;
    exp_rdy = 1'b1;

    // D with all-ones field, CB with only the sign bit, IW halfword 3, back to back
    base = $urandom();
    fix.v64 = 64'hFFFF_FFFF_FFFF_FFFF; fix.e64 = 1'b0;
    fix.v32 = 32'hFFFF_FFFF;           fix.e32 = 1'b0;
    use_fix = 1'b1;
    drive((base & ~32'h001F_F000) | 32'h001F_F000, 3'b000);
    cycle();
    base = $urandom();
    fix.v64 = 64'hFFFF_FFFF_FFFC_0000; fix.e64 = 1'b0;
    fix.v32 = 32'hFFF0_0000;           fix.e32 = 1'b0;
    use_fix = 1'b1;
    drive((base & ~32'h00FF_FFE0) | (32'h0004_0000 << 5), 3'b001);
    cycle();
    base = $urandom();
    fix.v64 = 64'hABCD_0000_0000_0000; fix.e64 = 1'b0;
    fix.v32 = 32'h0;                   fix.e32 = 1'b1;
    use_fix = 1'b1;
    drive((base & ~32'h007F_FFE0) | (32'h3 << 21) | (32'hABCD << 5), 3'b100);
    cycle();
    drain();

    // Random formats with random back-pressure
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) drive($urandom(), 3'($urandom_range(0, 7)));
      else in_valid = 1'b0;
      cycle();
    end
    drain();

    // Stall: three inputs offered, two taken, third taken after release
    out_ready = 1'b0;
    drive($urandom(), 3'b010);
    cycle();
    drive($urandom(), 3'b011);
    cycle();
    drive($urandom(), 3'b001);
    cycle();
    chk("full_in_ready64", {63'd0, ir64}, 64'd0);
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    drain();

    // Illegal formats at full rate until the counter saturates
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      drive($urandom(), 3'b111);
      cycle();
    end
    drain();
    chk("errcnt_sat64", {56'd0, cnt64}, 64'd255);
    chk("errcnt_sat32", {56'd0, cnt32}, 64'd255);

    // Reset while FULL
    out_ready = 1'b0;
    drive($urandom(), 3'b000);
    cycle();
    drive($urandom(), 3'b110);
    cycle();
    #2;
    resetl = 1'b0;
    #1;
    chk_reset();
    sbq.delete();
    cnt64_m  = 0;
    cnt32_m  = 0;
    exp_rdy  = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    resetl = 1'b1;
    @(posedge CLK);
    #1;
    exp_rdy   = 1'b1;
    out_ready = 1'b1;
    drive($urandom(), 3'b010);
    cycle();
    drive($urandom(), 3'b100);
    cycle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
